// File: rtl/hdmi_display_timing_ctrl_if.sv
// Register-port bundle between a bus master (CPU/BFM) and the display timing controller.
// Strobes are single-cycle: WE commits WDATA to WADDR at the clock edge it is sampled high;
// RE captures RADDR and RDATA presents that word on the following cycle.
// There is no ready/backpressure and the slave accepts every strobe.
interface hdmi_display_timing_ctrl_if;
  logic        we;
  logic [5:0]  waddr;
  logic [31:0] wdata;
  logic        re;
  logic [5:0]  raddr;
  logic [31:0] rdata;

  modport master (output we, waddr, wdata, re, raddr, input rdata);
  modport slave  (input we, waddr, wdata, re, raddr, output rdata);
endinterface

// File: rtl/hdmi_display_timing_ctrl.sv
// Register-mapped raster timing generator with double-buffered per-plane scan-out bases.
// Timing changes land at frame end; base flips commit at the first vertical-blank line.
module hdmi_display_timing_ctrl #(
  parameter int          C_PLANES           = 2,
  parameter int          C_ADDR_WIDTH       = 64,
  parameter int          C_CNT_BITS         = 12,
  parameter logic [63:0] C_DEFAULT_BASE     = 64'h00000000_80000000,
  parameter int          C_DEFAULT_H_LAST   = 2199,
  parameter int          C_DEFAULT_V_LAST   = 1124,
  parameter int          C_DEFAULT_H_ACT    = 1920,
  parameter int          C_DEFAULT_V_ACT    = 1080,
  parameter int          C_DEFAULT_HS_START = 2008,
  parameter int          C_DEFAULT_HS_END   = 2052,
  parameter int          C_DEFAULT_VS_START = 1084,
  parameter int          C_DEFAULT_VS_END   = 1089
) (
  input  logic                               i_clk,
  input  logic                               i_rst,
  hdmi_display_timing_ctrl_if.slave          s_reg,
  output logic [C_PLANES*C_ADDR_WIDTH-1:0]   o_front_base,
  output logic [C_CNT_BITS-1:0]              o_act_width,
  output logic [C_CNT_BITS-1:0]              o_act_height,
  output logic [C_CNT_BITS-1:0]              o_hcnt,
  output logic [C_CNT_BITS-1:0]              o_vcnt,
  output logic                               o_de,
  output logic                               o_hsync,
  output logic                               o_vsync,
  output logic                               o_vblank_start,
  output logic [C_PLANES-1:0]                o_flip_done,
  output logic                               o_irq
);

  localparam int HI_W = C_ADDR_WIDTH - 32;

  typedef logic [C_CNT_BITS-1:0]   cnt_t;
  typedef logic [C_ADDR_WIDTH-1:0] addr_t;

  typedef struct packed {
    cnt_t h_act;
    cnt_t h_last;
    cnt_t v_act;
    cnt_t v_last;
    cnt_t hs_start;
    cnt_t hs_end;
    cnt_t vs_start;
    cnt_t vs_end;
  } timing_t;

  localparam cnt_t    C_ONE = cnt_t'(1);
  localparam addr_t   C_BASE_RST = C_DEFAULT_BASE[C_ADDR_WIDTH-1:0];
  localparam timing_t C_TIMING_RST = '{
    h_act:    cnt_t'(C_DEFAULT_H_ACT),
    h_last:   cnt_t'(C_DEFAULT_H_LAST),
    v_act:    cnt_t'(C_DEFAULT_V_ACT),
    v_last:   cnt_t'(C_DEFAULT_V_LAST),
    hs_start: cnt_t'(C_DEFAULT_HS_START),
    hs_end:   cnt_t'(C_DEFAULT_HS_END),
    vs_start: cnt_t'(C_DEFAULT_VS_START),
    vs_end:   cnt_t'(C_DEFAULT_VS_END)
  };

  logic                r_en;
  logic                r_irq_en;
  logic                r_irq;
  timing_t             r_sh;
  timing_t             r_live;
  cnt_t                r_hcnt;
  cnt_t                r_vcnt;
  logic                r_de;
  logic                r_hsync;
  logic                r_vsync;
  logic                r_vblank_pulse;
  logic [C_PLANES-1:0] r_flip_done;
  logic [C_PLANES-1:0] r_pending;
  logic [HI_W-1:0]     r_staged_hi [C_PLANES];
  addr_t               r_shadow    [C_PLANES];
  addr_t               r_front     [C_PLANES];
  logic [31:0]         r_rdata;

  logic    w_wr_ctrl;
  logic    w_wr_status;
  logic    w_en_nxt;
  logic    w_frame_end;
  logic    w_vblank_start;
  logic    w_vblank_lvl;
  timing_t w_live_nxt;
  cnt_t    w_hcnt_nxt;
  cnt_t    w_vcnt_nxt;
  logic [31:0] w_rdata;

  assign w_wr_ctrl      = s_reg.we && (s_reg.waddr == 6'h00);
  assign w_wr_status    = s_reg.we && (s_reg.waddr == 6'h01);
  assign w_en_nxt       = w_wr_ctrl ? s_reg.wdata[0] : r_en;
  assign w_frame_end    = r_en && (r_hcnt == r_live.h_last) && (r_vcnt == r_live.v_last);
  assign w_vblank_start = r_en && (r_hcnt == '0) && (r_vcnt == r_live.v_act);
  assign w_vblank_lvl   = r_en && (r_vcnt >= r_live.v_act);
  // Live timing follows the shadows freely while stopped, otherwise only at frame end.
  assign w_live_nxt     = (!r_en || w_frame_end) ? r_sh : r_live;

  // Registered outputs are computed from next-state values so they line up with the counters.
  always_comb begin
    w_hcnt_nxt = '0;
    w_vcnt_nxt = '0;
    if (w_en_nxt && r_en) begin
      if (r_hcnt == r_live.h_last) begin
        w_vcnt_nxt = (r_vcnt == r_live.v_last) ? '0 : r_vcnt + C_ONE;
      end else begin
        w_hcnt_nxt = r_hcnt + C_ONE;
        w_vcnt_nxt = r_vcnt;
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    case (s_reg.raddr)
      6'h00: w_rdata = {30'd0, r_irq_en, r_en};
      6'h01: begin
        w_rdata[31] = r_irq;
        w_rdata[0]  = w_vblank_lvl;
        for (int p = 0; p < C_PLANES; p++) w_rdata[4+p] = r_pending[p];
      end
      6'h02: w_rdata = {16'(r_sh.h_last), 16'(r_sh.h_act)};
      6'h03: w_rdata = {16'(r_sh.v_last), 16'(r_sh.v_act)};
      6'h04: w_rdata = {16'(r_sh.hs_end), 16'(r_sh.hs_start)};
      6'h05: w_rdata = {16'(r_sh.vs_end), 16'(r_sh.vs_start)};
      default: begin
        for (int p = 0; p < C_PLANES; p++) begin
          if (s_reg.raddr == 6'(16 + 2*p)) w_rdata = r_shadow[p][31:0];
          if (s_reg.raddr == 6'(17 + 2*p)) w_rdata = 32'(r_staged_hi[p]);
        end
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_en           <= 1'b0;
      r_irq_en       <= 1'b0;
      r_irq          <= 1'b0;
      r_sh           <= C_TIMING_RST;
      r_live         <= C_TIMING_RST;
      r_hcnt         <= '0;
      r_vcnt         <= '0;
      r_de           <= 1'b0;
      r_hsync        <= 1'b0;
      r_vsync        <= 1'b0;
      r_vblank_pulse <= 1'b0;
      r_flip_done    <= '0;
      r_pending      <= '0;
      r_rdata        <= '0;
      for (int p = 0; p < C_PLANES; p++) begin
        r_staged_hi[p] <= C_BASE_RST[C_ADDR_WIDTH-1:32];
        r_shadow[p]    <= C_BASE_RST;
        r_front[p]     <= C_BASE_RST;
      end
    end else begin
      if (w_wr_ctrl) begin
        r_en     <= s_reg.wdata[0];
        r_irq_en <= s_reg.wdata[1];
      end
      if (s_reg.we) begin
        case (s_reg.waddr)
          6'h02: begin
            r_sh.h_act  <= s_reg.wdata[C_CNT_BITS-1:0];
            r_sh.h_last <= s_reg.wdata[16 +: C_CNT_BITS];
          end
          6'h03: begin
            r_sh.v_act  <= s_reg.wdata[C_CNT_BITS-1:0];
            r_sh.v_last <= s_reg.wdata[16 +: C_CNT_BITS];
          end
          6'h04: begin
            r_sh.hs_start <= s_reg.wdata[C_CNT_BITS-1:0];
            r_sh.hs_end   <= s_reg.wdata[16 +: C_CNT_BITS];
          end
          6'h05: begin
            r_sh.vs_start <= s_reg.wdata[C_CNT_BITS-1:0];
            r_sh.vs_end   <= s_reg.wdata[16 +: C_CNT_BITS];
          end
          default: ;
        endcase
      end

      r_live  <= w_live_nxt;
      r_hcnt  <= w_hcnt_nxt;
      r_vcnt  <= w_vcnt_nxt;
      r_de    <= w_en_nxt && (w_hcnt_nxt < w_live_nxt.h_act) && (w_vcnt_nxt < w_live_nxt.v_act);
      r_hsync <= w_en_nxt && (w_hcnt_nxt >= w_live_nxt.hs_start) && (w_hcnt_nxt < w_live_nxt.hs_end);
      r_vsync <= w_en_nxt && (w_vcnt_nxt >= w_live_nxt.vs_start) && (w_vcnt_nxt < w_live_nxt.vs_end);
      r_vblank_pulse <= w_vblank_start;

      // A LO write racing vblank_start commits the old shadow and re-arms for next frame.
      for (int p = 0; p < C_PLANES; p++) begin
        r_flip_done[p] <= w_vblank_start && r_pending[p];
        if (w_vblank_start && r_pending[p]) r_front[p] <= r_shadow[p];
        if (s_reg.we && (s_reg.waddr == 6'(16 + 2*p))) begin
          r_shadow[p]  <= {r_staged_hi[p], s_reg.wdata};
          r_pending[p] <= 1'b1;
        end else if (w_vblank_start) begin
          r_pending[p] <= 1'b0;
        end
        if (s_reg.we && (s_reg.waddr == 6'(17 + 2*p))) r_staged_hi[p] <= s_reg.wdata[HI_W-1:0];
      end

      if (w_vblank_start && r_irq_en) r_irq <= 1'b1;
      else if (w_wr_status && s_reg.wdata[31]) r_irq <= 1'b0;

      if (s_reg.re) r_rdata <= w_rdata;
    end
  end

  for (genvar gp = 0; gp < C_PLANES; gp++) begin : g_base
    assign o_front_base[gp*C_ADDR_WIDTH +: C_ADDR_WIDTH] = r_front[gp];
  end

  assign s_reg.rdata    = r_rdata;
  assign o_act_width    = r_live.h_act;
  assign o_act_height   = r_live.v_act;
  assign o_hcnt         = r_hcnt;
  assign o_vcnt         = r_vcnt;
  assign o_de           = r_de;
  assign o_hsync        = r_hsync;
  assign o_vsync        = r_vsync;
  assign o_vblank_start = r_vblank_pulse;
  assign o_flip_done    = r_flip_done;
  assign o_irq          = r_irq && r_irq_en;

endmodule

// File: tb/tb_hdmi_display_timing_ctrl.sv
// Directed bench for hdmi_display_timing_ctrl: default raster line, reduced-raster frames,
// deferred flips, same-cycle flip race, IRQ set/clear race, deferred timing change, mid-frame reset.
module tb_hdmi_display_timing_ctrl;
  localparam logic [63:0] DEF_BASE = 64'h00000000_80000000;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [127:0] front_base;
  logic [11:0]  act_width, act_height, hcnt, vcnt;
  logic         de, hsync, vsync, vblank_start, irq;
  logic [1:0]   flip_done;

  int tests_run = 0;
  int tests_failed = 0;

  hdmi_display_timing_ctrl_if bus ();

  hdmi_display_timing_ctrl dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .s_reg          (bus),
    .o_front_base   (front_base),
    .o_act_width    (act_width),
    .o_act_height   (act_height),
    .o_hcnt         (hcnt),
    .o_vcnt         (vcnt),
    .o_de           (de),
    .o_hsync        (hsync),
    .o_vsync        (vsync),
    .o_vblank_start (vblank_start),
    .o_flip_done    (flip_done),
    .o_irq          (irq)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // driver tasks: all start and end at a falling edge
  task automatic write_reg(input logic [5:0] a, input logic [31:0] d);
    bus.we = 1'b1; bus.waddr = a; bus.wdata = d;
    @(negedge clk);
    bus.we = 1'b0;
  endtask

  task automatic read_reg(input logic [5:0] a, output logic [31:0] d);
    bus.re = 1'b1; bus.raddr = a;
    @(negedge clk);
    bus.re = 1'b0;
    d = bus.rdata;
  endtask

  task automatic wait_hv(input logic [11:0] h, input logic [11:0] v);
    bit found = 0;
    for (int i = 0; i < 2000; i++) begin
      if (hcnt == h && vcnt == v) begin found = 1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!found) begin
      tests_failed++;
      $display("FAIL wait_hv: position h=%0d v=%0d never reached (now h=%0d v=%0d)", h, v, hcnt, vcnt);
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    tests_run++;
    if (front_base !== {DEF_BASE, DEF_BASE}) begin tests_failed++; $display("FAIL reset_front_base: got %h expected %h", front_base, {DEF_BASE, DEF_BASE}); end
    tests_run++;
    if ({act_width, act_height} !== {12'd1920, 12'd1080}) begin tests_failed++; $display("FAIL reset_act: got %0d/%0d expected 1920/1080", act_width, act_height); end
    tests_run++;
    if ({hcnt, vcnt, de, hsync, vsync, vblank_start, flip_done, irq} !== '0) begin tests_failed++; $display("FAIL reset_outputs: got h=%0d v=%0d de=%b hs=%b vs=%b vb=%b fd=%b irq=%b expected all 0", hcnt, vcnt, de, hsync, vsync, vblank_start, flip_done, irq); end
    read_reg(6'h00, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL reset_ctrl: got %h expected 00000000", d); end
    read_reg(6'h02, d);
    tests_run++;
    if (d !== 32'h0897_0780) begin tests_failed++; $display("FAIL reset_h_reg: got %h expected 08970780", d); end
    read_reg(6'h03, d);
    tests_run++;
    if (d !== 32'h0464_0438) begin tests_failed++; $display("FAIL reset_v_reg: got %h expected 04640438", d); end
    read_reg(6'h04, d);
    tests_run++;
    if (d !== 32'h0804_07D8) begin tests_failed++; $display("FAIL reset_hsync_reg: got %h expected 080407d8", d); end
    read_reg(6'h10, d);
    tests_run++;
    if (d !== 32'h8000_0000) begin tests_failed++; $display("FAIL reset_base_lo0: got %h expected 80000000", d); end
    write_reg(6'h20, 32'hDEAD_BEEF);
    read_reg(6'h20, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL unmapped_read: got %h expected 00000000", d); end
  endtask

  task automatic test_default_line();
    int de_cnt = 0;
    int hs_first = -1;
    int hs_last = -1;
    int vs_cnt = 0;
    write_reg(6'h00, 32'h1);
    for (int i = 0; i < 2200; i++) begin
      if (de) de_cnt++;
      if (vsync) vs_cnt++;
      if (hsync) begin
        if (hs_first < 0) hs_first = int'(hcnt);
        hs_last = int'(hcnt);
      end
      @(negedge clk);
    end
    tests_run++;
    if (de_cnt != 1920) begin tests_failed++; $display("FAIL default_de_count: got %0d expected 1920", de_cnt); end
    tests_run++;
    if (hs_first != 2008 || hs_last != 2051) begin tests_failed++; $display("FAIL default_hsync_range: got %0d..%0d expected 2008..2051", hs_first, hs_last); end
    tests_run++;
    if (vs_cnt != 0 || hcnt !== 12'd0 || vcnt !== 12'd1) begin tests_failed++; $display("FAIL default_line_wrap: got vs=%0d h=%0d v=%0d expected 0/0/1", vs_cnt, hcnt, vcnt); end
    write_reg(6'h00, 32'h0);
    tests_run++;
    if (hcnt !== 12'd0 || vcnt !== 12'd0 || de !== 1'b0) begin tests_failed++; $display("FAIL disable_clears: got h=%0d v=%0d de=%b expected 0/0/0", hcnt, vcnt, de); end
  endtask

  // 16 x 7 raster: active 8 x 4, hsync [10,12), vsync line 5
  task automatic test_small_timing();
    int de_cnt = 0, hs_cnt = 0, vs_cnt = 0, vb_cnt = 0;
    write_reg(6'h02, 32'h000F_0008);
    write_reg(6'h03, 32'h0006_0004);
    write_reg(6'h04, 32'h000C_000A);
    write_reg(6'h05, 32'h0006_0005);
    write_reg(6'h00, 32'h1);
    tests_run++;
    if (act_width !== 12'd8 || act_height !== 12'd4) begin tests_failed++; $display("FAIL small_act: got %0d/%0d expected 8/4", act_width, act_height); end
    for (int i = 0; i < 112; i++) begin
      if (de) de_cnt++;
      if (hsync) hs_cnt++;
      if (vsync) vs_cnt++;
      if (vblank_start) vb_cnt++;
      @(negedge clk);
    end
    tests_run++;
    if (de_cnt != 32) begin tests_failed++; $display("FAIL small_de_count: got %0d expected 32", de_cnt); end
    tests_run++;
    if (hs_cnt != 14 || vs_cnt != 16) begin tests_failed++; $display("FAIL small_sync_count: got hs=%0d vs=%0d expected 14/16", hs_cnt, vs_cnt); end
    tests_run++;
    if (vb_cnt != 1) begin tests_failed++; $display("FAIL small_vblank_pulses: got %0d expected 1", vb_cnt); end
    tests_run++;
    if (hcnt !== 12'd0 || vcnt !== 12'd0) begin tests_failed++; $display("FAIL small_frame_wrap: got h=%0d v=%0d expected 0/0", hcnt, vcnt); end
  endtask

  task automatic test_flip();
    logic [31:0] d;
    int fd0 = 0, fd1 = 0, early = 0;
    logic [11:0] ph = '1, pv = '1;
    wait_hv(12'd0, 12'd1);
    write_reg(6'h11, 32'h1);
    write_reg(6'h10, 32'h2000_0000);
    read_reg(6'h01, d);
    tests_run++;
    if (d !== 32'h10) begin tests_failed++; $display("FAIL flip_pending_set: got %h expected 00000010", d); end
    for (int i = 0; i < 224; i++) begin
      if (flip_done[1]) fd1++;
      if (flip_done[0]) begin
        if (fd0 == 0) begin ph = hcnt; pv = vcnt; end
        fd0++;
      end else if (fd0 == 0 && front_base[63:0] !== DEF_BASE) begin
        early++;
      end
      @(negedge clk);
    end
    tests_run++;
    if (early != 0) begin tests_failed++; $display("FAIL flip_early: got %0d cycles with base changed before commit, expected 0", early); end
    tests_run++;
    if (fd0 != 1 || fd1 != 0) begin tests_failed++; $display("FAIL flip_done_pulses: got p0=%0d p1=%0d expected 1/0", fd0, fd1); end
    tests_run++;
    if (ph !== 12'd1 || pv !== 12'd4) begin tests_failed++; $display("FAIL flip_position: got h=%0d v=%0d expected 1/4", ph, pv); end
    tests_run++;
    if (front_base[63:0] !== 64'h1_2000_0000 || front_base[127:64] !== DEF_BASE) begin tests_failed++; $display("FAIL flip_base: got %h expected %h", front_base, {DEF_BASE, 64'h1_2000_0000}); end
    read_reg(6'h01, d);
    tests_run++;
    if (d[5:4] !== 2'b00) begin tests_failed++; $display("FAIL flip_pending_clear: got %b expected 00", d[5:4]); end
  endtask

  task automatic test_flip_same_cycle();
    logic [31:0] d;
    bit seen = 0;
    wait_hv(12'd0, 12'd1);
    write_reg(6'h12, 32'h0000_A000);
    wait_hv(12'd0, 12'd4);
    write_reg(6'h12, 32'h0000_B000);
    tests_run++;
    if (flip_done !== 2'b10 || front_base[127:64] !== 64'hA000) begin tests_failed++; $display("FAIL race_commit: got fd=%b base1=%h expected 10/a000", flip_done, front_base[127:64]); end
    read_reg(6'h01, d);
    tests_run++;
    if (d !== 32'h21) begin tests_failed++; $display("FAIL race_pending: got %h expected 00000021", d); end
    for (int i = 0; i < 300; i++) begin
      if (flip_done[1]) begin seen = 1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!seen || front_base[127:64] !== 64'hB000) begin tests_failed++; $display("FAIL race_next_frame: got seen=%0d base1=%h expected 1/b000", seen, front_base[127:64]); end
  endtask

  task automatic test_irq();
    logic [31:0] d;
    bit seen = 0;
    write_reg(6'h00, 32'h3);
    for (int i = 0; i < 300; i++) begin
      if (vblank_start) begin seen = 1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!seen || irq !== 1'b1) begin tests_failed++; $display("FAIL irq_set: got seen=%0d irq=%b expected 1/1", seen, irq); end
    read_reg(6'h01, d);
    tests_run++;
    if (d !== 32'h8000_0001) begin tests_failed++; $display("FAIL irq_status: got %h expected 80000001", d); end
    wait_hv(12'd0, 12'd4);
    write_reg(6'h01, 32'h8000_0000);
    tests_run++;
    if (irq !== 1'b1) begin tests_failed++; $display("FAIL irq_set_wins: got %b expected 1", irq); end
    write_reg(6'h01, 32'h8000_0000);
    tests_run++;
    if (irq !== 1'b0) begin tests_failed++; $display("FAIL irq_clear: got %b expected 0", irq); end
  endtask

  task automatic test_timing_change();
    int de_cnt = 0;
    logic [11:0] hmax = '0;
    wait_hv(12'd0, 12'd1);
    write_reg(6'h02, 32'h0063_0040);
    wait_hv(12'd15, 12'd6);
    tests_run++;
    if (act_width !== 12'd8) begin tests_failed++; $display("FAIL timing_deferred: got %0d expected 8", act_width); end
    @(negedge clk);
    tests_run++;
    if (act_width !== 12'd64 || hcnt !== 12'd0 || vcnt !== 12'd0) begin tests_failed++; $display("FAIL timing_applied: got w=%0d h=%0d v=%0d expected 64/0/0", act_width, hcnt, vcnt); end
    for (int i = 0; i < 100; i++) begin
      if (de) de_cnt++;
      if (hcnt > hmax) hmax = hcnt;
      @(negedge clk);
    end
    tests_run++;
    if (de_cnt != 64 || hmax !== 12'd99) begin tests_failed++; $display("FAIL timing_new_line: got de=%0d hmax=%0d expected 64/99", de_cnt, hmax); end
    tests_run++;
    if (hcnt !== 12'd0 || vcnt !== 12'd1) begin tests_failed++; $display("FAIL timing_wrap: got h=%0d v=%0d expected 0/1", hcnt, vcnt); end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    bit seen = 0;
    for (int i = 0; i < 1000; i++) begin
      if (vblank_start) begin seen = 1; break; end
      @(negedge clk);
    end
    tests_run++;
    if (!seen || irq !== 1'b1) begin tests_failed++; $display("FAIL pre_reset_irq: got seen=%0d irq=%b expected 1/1", seen, irq); end
    write_reg(6'h10, 32'h0000_5555);
    wait_hv(12'd37, 12'd5);
    rst = 1'b1;
    @(negedge clk);
    tests_run++;
    if (hcnt !== 12'd0 || vcnt !== 12'd0 || irq !== 1'b0 || de !== 1'b0) begin tests_failed++; $display("FAIL midreset_counters: got h=%0d v=%0d irq=%b de=%b expected 0/0/0/0", hcnt, vcnt, irq, de); end
    tests_run++;
    if (front_base !== {DEF_BASE, DEF_BASE} || act_width !== 12'd1920) begin tests_failed++; $display("FAIL midreset_base: got %h w=%0d expected %h/1920", front_base, act_width, {DEF_BASE, DEF_BASE}); end
    rst = 1'b0;
    read_reg(6'h01, d);
    tests_run++;
    if (d !== 32'h0) begin tests_failed++; $display("FAIL midreset_status: got %h expected 00000000", d); end
  endtask

  initial begin
    bus.we = 1'b0; bus.waddr = '0; bus.wdata = '0;
    bus.re = 1'b0; bus.raddr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    test_reset();
    test_default_line();
    test_small_timing();
    test_flip();
    test_flip_same_cycle();
    test_irq();
    test_timing_change();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
